// File: rtl/q_8_29_pkg.sv
// Shared types and widths for the q_8_29 control unit.
package q_8_29_pkg;

    localparam int STATE_W = 3;
    localparam int DEC_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

endpackage

// File: rtl/dec_3to8.sv
// Combinational binary-to-one-hot decoder; one output line per state code.
module dec_3to8
    import q_8_29_pkg::*;
(
    input  logic [STATE_W-1:0] i_bin,
    output logic [DEC_W-1:0]   o_dec
);

    always_comb begin
        o_dec        = '0;
        o_dec[i_bin] = 1'b1;
    end

endmodule

// File: rtl/q_8_29_ctrl.sv
// Eight-state Moore control FSM steered by x/y/F/E; exposes state code and one-hot decode.
module q_8_29_ctrl
    import q_8_29_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               y,
    input  logic               F,
    input  logic               E,
    output logic [STATE_W-1:0] state,
    output logic [DEC_W-1:0]   dec_out
);

    state_t r_state;

    // Each qualifier is only looked at in its own state; elsewhere it is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            unique case (r_state)
                S0: begin
                    if (x)      r_state <= S1;
                    else if (y) r_state <= S2;
                    else        r_state <= S0;
                end
                S1: r_state <= S2;
                S2: r_state <= F ? S3 : S4;
                S3: r_state <= S0;
                S4: r_state <= E ? S5 : S6;
                S5: r_state <= S0;
                S6: r_state <= S7;
                S7: r_state <= S0;
                default: r_state <= S0;
            endcase
        end
    end

    assign state = r_state;

    dec_3to8 u_dec (
        .i_bin (r_state),
        .o_dec (dec_out)
    );

endmodule

// File: tb/tb_q_8_29_ctrl.sv
// Self-checking bench for q_8_29_ctrl: directed path tests plus randomized run against a rule model.
module tb_q_8_29_ctrl;

    logic       clk;
    logic       rst;
    logic       x, y, F, E;
    logic [2:0] state;
    logic [7:0] dec_out;

    int checks = 0;
    int errors = 0;
    int m_state = 0;

    q_8_29_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .F       (F),
        .E       (E),
        .state   (state),
        .dec_out (dec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Successor tables: a qualified state takes "hit" when its qualifier is 1, else "miss".
    int succ_hit  [8] = '{1, 2, 3, 0, 5, 0, 7, 0};
    int succ_miss [8] = '{0, 2, 4, 0, 6, 0, 7, 0};

    function automatic int model_next(int s, logic ix, logic iy, logic iF, logic iE);
        if (s == 0) return ix ? 1 : (iy ? 2 : 0);
        if (s == 2) return iF ? succ_hit[s] : succ_miss[s];
        if (s == 4) return iE ? succ_hit[s] : succ_miss[s];
        return succ_hit[s];
    endfunction

    task automatic drive(logic r, logic ix, logic iy, logic iF, logic iE);
        @(negedge clk);
        rst = r; x = ix; y = iy; F = iF; E = iE;
    endtask

    task automatic tick();
        @(posedge clk);
        m_state = rst ? 0 : model_next(m_state, x, y, F, E);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_dec;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (state !== 3'd0 || dec_out !== 8'h01) begin
                errors++;
                $display("FAIL reset_hold: state=%0d dec=%h expected state=0 dec=01", state, dec_out);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_dec = 8'h01;
            checks++;
            if (state !== 3'd0 || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL reset_idle: state=%0d dec=%h expected state=0 dec=%h", state, dec_out, exp_dec);
            end
        end
    endtask

    task automatic test_x_path();
        int         exp_seq [7] = '{1, 2, 4, 6, 7, 0, 1};
        logic [7:0] exp_dec;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_dec = 8'h01 << exp_seq[i];
            checks++;
            if (int'(state) != exp_seq[i] || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL x_path[%0d]: state=%0d dec=%h expected state=%0d dec=%h",
                         i, state, dec_out, exp_seq[i], exp_dec);
            end
        end
    endtask

    task automatic test_y_path();
        int         exp_seq [5] = '{2, 4, 6, 7, 0};
        logic [7:0] exp_dec;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_dec = 8'h01 << exp_seq[i];
            checks++;
            if (int'(state) != exp_seq[i] || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL y_path[%0d]: state=%0d dec=%h expected state=%0d dec=%h",
                         i, state, dec_out, exp_seq[i], exp_dec);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (state !== 3'd1 || dec_out !== 8'h02) begin
            errors++;
            $display("FAIL xy_priority: state=%0d dec=%h expected state=1 dec=02", state, dec_out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_f_branch();
        int         exp_seq [6] = '{2, 3, 0, 2, 3, 0};
        logic [7:0] exp_dec;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_dec = 8'h01 << exp_seq[i];
            checks++;
            if (int'(state) != exp_seq[i] || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL f_branch[%0d]: state=%0d dec=%h expected state=%0d dec=%h",
                         i, state, dec_out, exp_seq[i], exp_dec);
            end
        end
    endtask

    task automatic test_e_branch();
        int         exp_seq [4] = '{2, 4, 5, 0};
        logic [7:0] exp_dec;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            tick();
            exp_dec = 8'h01 << exp_seq[i];
            checks++;
            if (int'(state) != exp_seq[i] || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL e_branch[%0d]: state=%0d dec=%h expected state=%0d dec=%h",
                         i, state, dec_out, exp_seq[i], exp_dec);
            end
        end
    endtask

    task automatic test_midrun_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (state !== 3'd6) begin
            errors++;
            $display("FAIL reach_s6: state=%0d expected 6", state);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (state !== 3'd0 || dec_out !== 8'h01) begin
            errors++;
            $display("FAIL midrun_reset: state=%0d dec=%h expected state=0 dec=01", state, dec_out);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        // rst pulse confined to the low phase must not be seen
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (state !== 3'd2 || dec_out !== 8'h04) begin
            errors++;
            $display("FAIL rst_glitch: state=%0d dec=%h expected state=2 dec=04", state, dec_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_dec;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            if (x && ($urandom_range(0, 2) != 0)) x = 1'b0;
            tick();
            exp_dec = 8'h01 << m_state;
            checks++;
            if (int'(state) != m_state || dec_out !== exp_dec) begin
                errors++;
                $display("FAIL random[%0d]: state=%0d dec=%h expected state=%0d dec=%h",
                         i, state, dec_out, m_state, exp_dec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; y = 1'b0; F = 1'b0; E = 1'b0;
        test_reset();
        test_x_path();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        test_y_path();
        test_f_branch();
        test_e_branch();
        test_midrun_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_8_29_ctrl.md
Name: q_8_29_ctrl

Overview:
- Eight-state Moore control FSM (S0..S7) steered by four qualifier inputs x, y, F, E.
- Exposes the binary state code and a one-hot decoded copy of it.
- Used as the control unit of a small datapath: each dec_out bit acts as a per-state control line.

Parameters:
- None. State width is fixed at 3 bits and decoder width at 8 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; forces S0.
- x  input  1  start qualifier, sampled in S0 only.
- y  input  1  alternate start qualifier, sampled in S0 only.
- F  input  1  branch qualifier, sampled in S2 only.
- E  input  1  branch qualifier, sampled in S4 only.
- state  output  3  current state code, S0=0 through S7=7.
- dec_out  output  8  one-hot decode of state; dec_out[i]=1 iff state==i.

Behaviour:
- Clocking and reset:
  - Single clock domain; one state register, 3 bits, updated on the rising edge of clk.
  - rst=1 at a rising edge loads S0, overriding all qualifiers.
  - Reset is synchronous: asserting rst between edges has no effect until the next edge.
  - Reset mid-sequence always returns to S0.
- Outputs after reset: state=3'd0, dec_out=8'h01.
- Outputs are Moore type: purely a function of the state register.
  - No combinational path from x/y/F/E to any output.
  - dec_out = 8'h01 << state. Exactly one bit is high at all times.
- Next-state rules (evaluated each edge when rst=0):
  - S0: x=1 -> S1; else y=1 -> S2; else stay S0. x has priority over y.
  - S1: -> S2, unconditional.
  - S2: F=1 -> S3; else -> S4.
  - S3: -> S0, unconditional.
  - S4: E=1 -> S5; else -> S6.
  - S5: -> S0, unconditional.
  - S6: -> S7, unconditional.
  - S7: -> S0, unconditional.
- Qualifiers not listed for a state are don't-care in that state.
- All eight codes are reachable, so no illegal-state recovery is needed. The default branch of the next-state logic goes to S0.
- Latency: each transition takes exactly one clock cycle. There is no handshake.
- Inputs are assumed synchronous to clk.

Decomposition:
- Shared package q_8_29_pkg:
  - enum typedef state_t, 3-bit logic, values S0..S7 = 0..7.
  - constants STATE_W=3 and DEC_W=8.
- One sub-module: dec_3to8, a combinational binary-to-one-hot decoder producing dec_out from state.
- Next-state logic and the state register stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 edges with x=1, y=1 -> state=0, dec_out=8'h01. Release rst with x=y=F=E=0 for 3 cycles -> stays S0.
- x path, x=1, others 0: after release, successive edges give S1,S2,S4,S6,S7,S0, then S1 again while x stays 1. dec_out tracks: 02,04,10,40,80,01.
- y path, x=0, y=1, F=E=0: S0->S2->S4->S6->S7->S0. Also check priority: x=1,y=1 in S0 -> S1.
- F branch, y=1, F=1: S0->S2->S3->S0, repeating. E is ignored in S2.
- E branch, y=1, F=0, E=1: S0->S2->S4->S5->S0. F=1 while in S4 has no effect.
- Mid-run reset: assert rst=1 while in S6 -> next edge S0, dec_out=8'h01. A rst pulse that does not span a rising edge causes no change.
